// File: rtl/ps2_pkg.sv
// Shared PS/2 keystroke types: sequencer states, scancode constants, FIFO entry
// layout and the make/break slot helpers used by the sequencer.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PREFIX,
        BYTE,
        GAP,
        INHIBIT
    } ps2_state_e;

    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BREAK  = 8'hF0;

    typedef struct packed {
        logic       extended;
        logic       shift;
        logic [7:0] code;
    } ps2_key_t;

    // Full sequence is 8 slots: 12 E0 code E0 F0 code F0 12; flags drop slots.
    function automatic logic slot_used(input logic [2:0] idx, input ps2_key_t k);
        case (idx)
            3'd0, 3'd6, 3'd7: slot_used = k.shift;
            3'd1, 3'd3:       slot_used = k.extended;
            default:          slot_used = 1'b1;
        endcase
    endfunction

    function automatic logic [7:0] slot_byte(input logic [2:0] idx, input ps2_key_t k);
        case (idx)
            3'd0, 3'd7: slot_byte = PS2_LSHIFT;
            3'd1, 3'd3: slot_byte = PS2_EXT;
            3'd4, 3'd6: slot_byte = PS2_BREAK;
            default:    slot_byte = k.code;
        endcase
    endfunction

    function automatic logic [2:0] first_slot(input ps2_key_t k);
        first_slot = k.shift ? 3'd0 : (k.extended ? 3'd1 : 3'd2);
    endfunction

    // Returns {found, idx} of the next used slot after idx.
    function automatic logic [3:0] next_slot(input logic [2:0] idx, input ps2_key_t k);
        logic [2:0] s;
        next_slot = '0;
        for (int unsigned i = 7; i >= 1; i--) begin
            s = 3'(i);
            if (s > idx && slot_used(s, k)) next_slot = {1'b1, s};
        end
    endfunction

endpackage

// File: rtl/ps2_byte_tx.sv
// Serialises one byte as an 11-bit PS/2 device frame (start, 8 data LSB first,
// odd parity, stop); lines idle high, abort returns them high at once.
module ps2_byte_tx
    import ps2_pkg::*;
#(
    parameter int HALF = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       abort,
    output logic       go,
    output logic       done,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int CW = $clog2(2 * HALF);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(2 * HALF - 1);

    logic          active_q, active_d;
    logic [10:0]   frame_q, frame_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic          data_q, data_d;

    always_comb begin
        active_d = active_q;
        frame_d  = frame_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        clk_d    = clk_q;
        data_d   = data_q;
        done     = 1'b0;
        if (abort) begin
            active_d = 1'b0;
            clk_d    = 1'b1;
            data_d   = 1'b1;
        end else if (start) begin
            frame_d  = {1'b1, ~^data_in, data_in, 1'b0};
            active_d = 1'b1;
            bit_d    = '0;
            cnt_d    = '0;
            clk_d    = 1'b1;
            data_d   = 1'b0;
        end else if (active_q) begin
            if (cnt_q == FULL_M1) begin
                cnt_d = '0;
                clk_d = 1'b1;
                if (bit_q == 4'd10) begin
                    active_d = 1'b0;
                    done     = 1'b1;
                    data_d   = 1'b1;
                end else begin
                    bit_d  = bit_q + 4'd1;
                    data_d = frame_q[bit_q + 4'd1];
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HALF_M1) clk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            frame_q  <= '1;
            bit_q    <= '0;
            cnt_q    <= '0;
            clk_q    <= 1'b1;
            data_q   <= 1'b1;
        end else begin
            active_q <= active_d;
            frame_q  <= frame_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            data_q   <= data_d;
        end
    end

    assign go       = active_q;
    assign ps2_clk  = clk_q;
    assign ps2_data = data_q;

endmodule

// File: rtl/ps2_keystroke_tx.sv
// Keystroke FIFO plus make/break sequencer driving a PS/2 device transmitter.
// Define PS2_INHIBIT_EN to abort and resend a byte when the host pulls ps2_clk low.
module ps2_keystroke_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int PS2_HZ     = 12500,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_BITS   = 2
) (
    input  logic                        clk_25mhz,
    input  logic                        resetn,
    input  logic                        key_valid,
    output logic                        key_ready,
    input  logic [7:0]                  key_code,
    input  logic                        key_extended,
    input  logic                        key_shift,
    output logic                        ps2_clk,
    output logic                        ps2_data,
    input  logic                        ps2_clk_in,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] level
);

    localparam int HALF    = CLK_HZ / (2 * PS2_HZ);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int LW      = PW + 1;
    localparam int GAP_CYC = GAP_BITS * 2 * HALF;
    localparam int GW      = $clog2(GAP_CYC);
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    // GAP lasts one cycle short; the following LOAD/PREFIX/IDLE cycle completes it.
    localparam logic [GW-1:0] GAP_END = GW'(GAP_CYC - 2);

    ps2_state_e    state_q, state_d;
    ps2_key_t      key_q, key_d;
    ps2_key_t      fifo_mem_q [FIFO_DEPTH];
    ps2_key_t      head;
    logic [2:0]    slot_q, slot_d;
    logic [3:0]    nxt;
    logic [GW-1:0] gap_q, gap_d;
    logic [LW-1:0] level_q, level_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic          key_ready_q, key_ready_d;
    logic          push, pop;
    logic          byte_start, byte_abort, byte_go, byte_done;
    logic [7:0]    byte_val;

`ifdef PS2_INHIBIT_EN
    localparam int RW = $clog2(2 * HALF);
    localparam logic [RW-1:0] REL_END = RW'(2 * HALF - 1);
    logic          clk_in_meta_q, clk_in_sync_q;
    logic [RW-1:0] rel_q, rel_d;
`else
    logic unused_ps2_clk_in;
    assign unused_ps2_clk_in = ps2_clk_in;
`endif

    assign push = key_valid & key_ready_q;
    assign head = fifo_mem_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        key_ready_d = level_d < DEPTH_L;
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        slot_d     = slot_q;
        gap_d      = gap_q;
        pop        = 1'b0;
        byte_start = 1'b0;
        byte_abort = 1'b0;
        byte_val   = slot_byte(slot_q, key_q);
        nxt        = next_slot(slot_q, key_q);
`ifdef PS2_INHIBIT_EN
        rel_d      = rel_q;
`endif
        case (state_q)
            IDLE: if (level_q != '0) state_d = LOAD;
            LOAD: begin
                pop        = 1'b1;
                key_d      = head;
                slot_d     = first_slot(head);
                byte_val   = slot_byte(slot_d, head);
                byte_start = 1'b1;
                state_d    = BYTE;
            end
            PREFIX: begin
                byte_start = 1'b1;
                state_d    = BYTE;
            end
            BYTE: begin
`ifdef PS2_INHIBIT_EN
                if (!clk_in_sync_q && ps2_clk) begin
                    byte_abort = 1'b1;
                    rel_d      = '0;
                    state_d    = INHIBIT;
                end else if (byte_done) begin
                    gap_d   = '0;
                    state_d = GAP;
                end
`else
                if (byte_done) begin
                    gap_d   = '0;
                    state_d = GAP;
                end
`endif
            end
            GAP: begin
                if (gap_q == GAP_END) begin
                    if (nxt[3]) begin
                        slot_d  = nxt[2:0];
                        state_d = PREFIX;
                    end else if (level_q != '0) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
`ifdef PS2_INHIBIT_EN
            INHIBIT: begin
                if (!clk_in_sync_q) begin
                    rel_d = '0;
                end else if (rel_q == REL_END) begin
                    byte_start = 1'b1;
                    state_d    = BYTE;
                end else begin
                    rel_d = rel_q + RW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (push) fifo_mem_q[wr_ptr_q] <= '{extended: key_extended, shift: key_shift, code: key_code};
    end

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            key_q       <= '0;
            slot_q      <= '0;
            gap_q       <= '0;
            level_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            key_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            slot_q      <= slot_d;
            gap_q       <= gap_d;
            level_q     <= level_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            key_ready_q <= key_ready_d;
        end
    end

`ifdef PS2_INHIBIT_EN
    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            clk_in_meta_q <= 1'b1;
            clk_in_sync_q <= 1'b1;
            rel_q         <= '0;
        end else begin
            clk_in_meta_q <= ps2_clk_in;
            clk_in_sync_q <= clk_in_meta_q;
            rel_q         <= rel_d;
        end
    end
`endif

    ps2_byte_tx #(
        .HALF(HALF)
    ) u_byte_tx (
        .clk      (clk_25mhz),
        .rst_n    (resetn),
        .start    (byte_start),
        .data_in  (byte_val),
        .abort    (byte_abort),
        .go       (byte_go),
        .done     (byte_done),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    assign key_ready = key_ready_q;
    assign busy      = (state_q != IDLE) | byte_go;
    assign level     = level_q;

endmodule

// File: doc/ps2_keystroke_tx.md
PS2_KEYSTROKE_TX -- requirements
Module: ps2_keystroke_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 25000000, system clock frequency.
REQ-002 SHALL have parameter PS2_HZ, default 12500, PS/2 clock rate; HALF = CLK_HZ/(2*PS2_HZ) cycles (1000 at defaults).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, keystroke queue depth; power of 2, at least 2.
REQ-004 SHALL have parameter GAP_BITS, default 2, idle PS/2 bit periods between bytes.
REQ-005 SHALL have ports: clk_25mhz in 1 system clock.
REQ-006 SHALL have ports: resetn in 1 asynchronous active-low reset.
REQ-007 SHALL have ports: key_valid in 1, key_ready out 1 keystroke handshake.
REQ-008 SHALL have ports: key_code in 8 scancode; key_extended in 1 E0 prefix; key_shift in 1 wrap in left-shift.
REQ-009 SHALL have ports: ps2_clk out 1, ps2_data out 1 PS/2 lines, idle high.
REQ-010 SHALL have ports: ps2_clk_in in 1 sensed PS/2 clock line (host inhibit).
REQ-011 SHALL have ports: busy out 1 sequence in progress; level out $clog2(FIFO_DEPTH)+1 FIFO occupancy.

Function
REQ-012 SHALL accept a keystroke when key_valid && key_ready on a rising clock edge; key_ready = level < FIFO_DEPTH.
REQ-013 SHALL hold key_ready low when the FIFO is full, keep key_valid pending, and lose no entry.
REQ-014 SHALL expand each entry into make then break: [12 if shift][E0 if ext] code [E0 if ext] F0 code [F0 12 if shift]; 3 bytes plain, 8 bytes shift+extended.
REQ-015 SHALL frame each byte as start 0, 8 data bits LSB first, odd parity, stop 1: 11 bits.
REQ-016 SHALL use bit periods of 2*HALF cycles: ps2_data changes at period start, ps2_clk high for HALF cycles, then low for HALF cycles.
REQ-017 SHALL hold both lines high for GAP_BITS*2*HALF cycles after each stop bit.
REQ-018 SHALL implement FSM states IDLE, LOAD, PREFIX, BYTE, GAP, INHIBIT; IDLE->LOAD when FIFO is non-empty; LOAD pops the entry; the sequence completes GAP->IDLE (or GAP->LOAD when not empty).
REQ-019 SHALL assert busy in every state except IDLE; level updates the cycle after push/pop, and a simultaneous push and pop leaves level unchanged.
REQ-020 SHALL make the first ps2_data falling edge (start bit) occur 2 cycles after key accept into an empty idle block.
REQ-021 SHALL treat FIFO pointers as wrapping modulo FIFO_DEPTH.

Reset
REQ-022 SHALL, on resetn low, immediately force ps2_clk=1, ps2_data=1, busy=0, level=0, key_ready=0, FIFO empty, FSM IDLE.
REQ-023 SHALL abandon a partially sent byte or sequence on reset mid-operation and never resume it; key_ready rises the first cycle after resetn deasserts.

Configuration
REQ-024 SHALL, with PS2_INHIBIT_EN defined, double-flop sync ps2_clk_in; if it reads 0 while ps2_clk is driven high in BYTE, abort the byte, drive lines high, enter INHIBIT, wait until ps2_clk_in is high for 2*HALF continuous cycles, then resend the whole current byte from the start bit.
REQ-025 SHALL, without PS2_INHIBIT_EN, ignore ps2_clk_in, never enter INHIBIT, and contain no inhibit logic.

Structure
REQ-026 SHALL place in shared package ps2_pkg: FSM state enum, scancode constants (PS2_LSHIFT=8'h12, PS2_EXT=8'hE0, PS2_BREAK=8'hF0), and the keystroke entry struct {extended, shift, code}.
REQ-027 SHALL be split into sub-module ps2_byte_tx, which serialises one byte with start/go/done/abort; the sequencer and FIFO stay in ps2_keystroke_tx.

Verification (CLK_HZ=1000, PS2_HZ=100, HALF=5, FIFO_DEPTH=4, GAP_BITS=2)
REQ-028 SHALL cover: code 1C, no flags -> bytes 1C, F0, 1C on ps2_data sampled at ps2_clk falling edges; parity bits 0, 1, 0; busy low after the final gap.
REQ-029 SHALL cover: code 75, shift+extended -> bytes 12, E0, 75, E0, F0, 75, F0, 12 in order.
REQ-030 SHALL cover: 6 back-to-back valid cycles while busy -> 4 accepted, key_ready low with level=4, and the remainder accepted as entries drain, in order.
REQ-031 SHALL cover: resetn pulsed low mid-byte -> lines high the same cycle, level=0, and the next key is sent cleanly.
REQ-032 SHALL cover: with PS2_INHIBIT_EN, ps2_clk_in held low 30 cycles during bit 4 of E0 -> lines high, busy stays 1, and E0 is resent in full 10 cycles after release.
